// File: rtl/pop_uart_tx.sv
// 8N1 UART transmitter that streams a latched population vector out LSB-first, byte by byte.
// Optional build macro POPTX_SYNC_HEADER_EN prepends sync bytes 0xA5, 0x5A to every frame.
module pop_uart_tx #(
  parameter int POP_BITS     = 1875,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                transmit,
  input  logic [POP_BITS-1:0] population,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  localparam int NBYTES = (POP_BITS + 7) / 8;
`ifdef POPTX_SYNC_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = NBYTES + HDR;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW    = $clog2(NBYTES + 2);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [POP_BITS-1:0]   shreg_q, shreg_d;
  logic                  trans_q;
  logic                  tx_d, busy_d, done_d;
  logic                  start_edge, baud_end, shift_ok;
  logic [7:0]            cur_byte;

  assign start_edge = transmit && !trans_q && (state_q == IDLE);
  assign baud_end   = (baud_q == BAUD_LAST);

`ifdef POPTX_SYNC_HEADER_EN
  // Leaving a header byte must not consume population data.
  assign shift_ok = (idx_q > IW'(1));

  always_comb begin
    if (idx_d == '0)
      cur_byte = 8'hA5;
    else if (idx_d == IW'(1))
      cur_byte = 8'h5A;
    else
      cur_byte = 8'(shreg_d);
  end
`else
  assign shift_ok = 1'b1;
  assign cur_byte = 8'(shreg_d);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      trans_q <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      trans_q <= transmit;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          shreg_d = population;
          baud_d  = '0;
          bit_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7)
            state_d = STOP;
          else
            bit_d = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (idx_q < IDX_LAST) begin
            // Back-to-back bytes: straight into the next start bit.
            idx_d   = idx_q + 1'b1;
            state_d = START;
            if (shift_ok)
              shreg_d = shreg_q >> 8;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the next-state view so tx is glitch-free.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: doc/pop_uart_tx.md
Name: pop_uart_tx

Overview:
- UART 8N1 transmitter that serializes the final GA population once the generation controller raises its transmit request.
- Sits between the controller's population/uart_transmit outputs and the board TX pin.
- Latches the full population on the rising edge of the request and sends it as bytes, LSB-first.
- Reports busy and a one-cycle done pulse back to the controller side.

Parameters:
POP_BITS, 1875, width of the population vector.
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud).

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous active-high reset.
transmit  input  1  level request from the controller; only its rising edge starts a frame.
population  input  POP_BITS  population vector; sampled only at the start edge.
tx  output  1  UART serial line, idle high.
busy  output  1  high from the cycle after the start edge until the last stop bit completes.
done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (async, rst=1) forces: tx=1, busy=0, done=0, state=IDLE, bit/byte/baud counters=0, transmit-edge register=0, shift register=0.
- NBYTES = ceil(POP_BITS/8); 235 at the default.
- Byte k = population[8k+7:8k]. Bit positions at or above POP_BITS are transmitted as 0.
- Start edge: transmit=1 and the previous-cycle sample of transmit=0, in IDLE.
  - Population is latched into a POP_BITS-wide shift register in the same cycle.
  - Next cycle: state=START, busy=1, tx=0.
- Edges while busy are ignored. Holding transmit high never retriggers; it must drop and rise again.
- transmit high on the first clock after reset counts as an edge.
- Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter from 0 to CLKS_PER_BIT-1.
- States:
  - IDLE: tx=1. Go to START on a start edge.
  - START: tx=0 for one bit time, then DATA.
  - DATA: tx=current byte bit i, i=0..7, LSB first. After bit 7, go to STOP.
  - STOP: tx=1 for one bit time. Then either:
    - if the byte index is below NBYTES-1: increment the index, shift the register right by 8, go to START with no idle gap;
    - otherwise: go to IDLE, pulse done=1 for exactly one cycle, drop busy in the same cycle.
- Frame duration from the first tx=0 to the done pulse: NBYTES*10*CLKS_PER_BIT cycles.
- Changes on population during a frame do not affect transmitted data.
- Reset asserted mid-frame aborts immediately:
  - tx returns to 1 asynchronously;
  - no done pulse;
  - a fresh edge is required after reset releases.
- Counter widths: baud counter ceil(log2(CLKS_PER_BIT)) bits, byte index ceil(log2(NBYTES+2)) bits. Counters never wrap within a frame.

Optional Feature:
- Macro: POPTX_SYNC_HEADER_EN.
- Defined: two header bytes, 0xA5 then 0x5A, are sent before byte 0 in the same 8N1 format.
  - Frame length becomes (NBYTES+2)*10*CLKS_PER_BIT cycles.
  - busy and done cover the header.
- Undefined: no header; the frame starts directly with population byte 0.
- All port and reset behaviour is identical in both builds.

Test Plan:
- Reset idle: POP_BITS=20, CLKS_PER_BIT=4. Hold rst=1 for 3 cycles, then release with transmit=0 -> tx=1, busy=0, done=0 for 50 cycles.
- Basic frame: population=20'hABCDE, pulse transmit high for 1 cycle -> tx carries bytes 0xDE, 0xBC, 0x0A as 8N1, LSB first, 4 cycles/bit.
  - busy is high for 120 cycles.
  - done is high for exactly 1 cycle, coincident with busy falling.
- Level hold and data stability: hold transmit=1 for 500 cycles and change population to 20'h12345 mid-frame -> exactly one frame of 0xDE, 0xBC, 0x0A. Drop and re-raise transmit -> a second frame of 0x45, 0x23, 0x01.
- Ignored retrigger: raise a new transmit edge at cycle 40 of a frame -> no restart, still 120 busy cycles, single done.
- Mid-frame reset: assert rst at cycle 60 of a frame -> tx=1 asynchronously, busy=0, no done pulse. A subsequent edge gives a full, correct 120-cycle frame.
- With POPTX_SYNC_HEADER_EN defined: population=20'hABCDE -> bytes 0xA5, 0x5A, 0xDE, 0xBC, 0x0A; busy high for 200 cycles.
